rgb_pwm_driver: RTL



---
 rtl/rgb_pwm_driver.sv | 99 +++++++++
 1 files changed

// File: rtl/rgb_pwm_driver.sv
// RGB LED PWM driver with optional blink, fed by the 2-bit RGB comparator.
// Inputs are latched only at PWM period boundaries to avoid runt pulses.
module rgb_pwm_driver #(
    parameter int PRESCALE      = 4,
    parameter int PWM_BITS      = 4,
    parameter int BLINK_PERIODS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                red,
    input  logic                green,
    input  logic                blue,
    input  logic [PWM_BITS-1:0] duty,
    input  logic                blink_en,
    output logic                led_r,
    output logic                led_g,
    output logic                led_b,
    output logic                period_start
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int BW = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_PERIODS - 1);

    logic [PW-1:0]       r_presc_cnt;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [2:0]          r_color_q;
    logic [PWM_BITS-1:0] r_duty_q;
    logic                r_blink_en_q;
    logic [BW-1:0]       r_blink_cnt;
    logic                r_blink_phase;

    logic w_step;
    logic w_period_start;
    logic w_on;

    assign w_step         = (r_presc_cnt == PRESC_MAX);
    assign w_period_start = w_step & (&r_pwm_cnt);

    // Prescaler: one PWM step every PRESCALE clocks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc_cnt <= '0;
        end else if (w_step) begin
            r_presc_cnt <= '0;
        end else begin
            r_presc_cnt <= r_presc_cnt + 1'b1;
        end
    end

    // PWM step counter; wraps naturally at the end of each period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pwm_cnt <= '0;
        end else if (w_step) begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
        end
    end

    // Capture colour, duty and blink enable only at the period boundary.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_color_q    <= '0;
            r_duty_q     <= '0;
            r_blink_en_q <= 1'b0;
        end else if (w_period_start) begin
            r_color_q    <= {red, green, blue};
            r_duty_q     <= duty;
            r_blink_en_q <= blink_en;
        end
    end

    // Blink phase: toggles every BLINK_PERIODS periods while enabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b1;
        end else if (w_period_start) begin
            if (!blink_en) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= 1'b1;
            end else if (r_blink_cnt == BLINK_MAX) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    assign w_on = (r_pwm_cnt < r_duty_q) & (~r_blink_en_q | r_blink_phase);

    assign led_r        = r_color_q[2] & w_on;
    assign led_g        = r_color_q[1] & w_on;
    assign led_b        = r_color_q[0] & w_on;
    assign period_start = w_period_start;

endmodule
